// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock,
// LSB first, with a single full-subtractor cell and a borrow flip-flop.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 2)
// Ports:
//   clk     system clock, rising-edge active
//   rst     asynchronous active-high reset
//   start   begin a subtraction (sampled only while idle)
//   a, b    minuend / subtrahend, captured on the accepting edge
//   diff    registered a - b mod 2^WIDTH
//   borrow  unsigned borrow out (a < b)
//   ovf     signed overflow of the subtraction
//   busy    high while bits are being processed
//   done    one-cycle pulse when diff/borrow/ovf update
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] sa_q,     sa_d;
    logic [WIDTH-1:0] sb_q,     sb_d;
    // Only WIDTH-1 bits are kept: the top result bit is the current
    // cycle's d and goes straight into diff on the final edge.
    logic [WIDTH-2:0] r_q,      r_d;
    logic             bw_q,     bw_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             am_q,     am_d;
    logic             bm_q,     bm_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;

    // Full-subtractor cell
    logic             d_bit;
    logic             bw_nxt;
    logic [WIDTH-1:0] r_shift;

    assign d_bit   = sa_q[0] ^ sb_q[0] ^ bw_q;
    assign bw_nxt  = (~sa_q[0] & sb_q[0])
                   | (~(sa_q[0] ^ sb_q[0]) & bw_q);
    assign r_shift = {d_bit, r_q};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        r_d      = r_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        am_d     = am_q;
        bm_d     = bm_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bw_d  = bw_nxt;
                r_d   = r_shift[WIDTH-1:1];
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    diff_d   = r_shift;
                    borrow_d = bw_nxt;
                    // Overflow only when operand signs differ and the
                    // result sign disagrees with the minuend.
                    ovf_d    = (am_q != bm_q) & (d_bit != am_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            r_q      <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            am_q     <= 1'b0;
            bm_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            r_q      <= r_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            am_q     <= am_d;
            bm_q     <= bm_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=4): random and directed operands
// checked against an integer-arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [5:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
        int ux, uy, sx, sy, sd, ud;
        logic o, bo;
        logic [W-1:0] dd;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
        sd = sx - sy;
        o  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        bo = (ux < uy);
        ud = (ux - uy + (1 << W)) % (1 << W);
        dd = ud[W-1:0];
        return {o, bo, dd};
    endfunction

    task automatic check_result(input string tag,
                                input logic [W-1:0] x,
                                input logic [W-1:0] y);
        logic [5:0] m;
        m = model(x, y);
        check({tag, ".diff"},   32'(diff),   32'(m[3:0]));
        check({tag, ".borrow"}, 32'(borrow), 32'(m[4]));
        check({tag, ".ovf"},    32'(ovf),    32'(m[5]));
    endtask

    // One operation; with disturb, a/b/start are scrambled while it runs.
    task automatic run_op(input string tag,
                          input logic [W-1:0] x,
                          input logic [W-1:0] y,
                          input bit disturb);
        int nb;
        int nd;
        bit seen;
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb    = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) nb++;
                if (disturb) begin
                    a     = W'($urandom);
                    b     = W'($urandom);
                    start = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
        end
        check({tag, ".done_seen"},  32'(seen), 32'(1));
        check({tag, ".busy_cyc"},   32'(nb),   32'(W));
        check({tag, ".busy_in_dn"}, 32'(busy), 32'(0));
        check_result(tag, x, y);
        if (disturb) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            nd = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done || busy) nd++;
            end
            check({tag, ".extra_ops"}, 32'(nd), 32'(0));
            check_result({tag, ".hold"}, x, y);
        end else begin
            @(negedge clk);
            check({tag, ".done_1cyc"}, 32'(done), 32'(0));
        end
    endtask

    initial begin
        int nd;
        int nb;
        int prev;
        int pulses;
        logic [W-1:0] ca;
        logic [W-1:0] cb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst.diff",   32'(diff),   32'(0));
        check("rst.borrow", 32'(borrow), 32'(0));
        check("rst.ovf",    32'(ovf),    32'(0));
        check("rst.busy",   32'(busy),   32'(0));
        check("rst.done",   32'(done),   32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("unsigned", 4'd12, 4'd5, 1'b0);
        run_op("sovf",     4'd3,  4'd9, 1'b0);
        run_op("eq15",     4'd15, 4'd15, 1'b0);
        run_op("eq0",      4'd0,  4'd0, 1'b0);
        run_op("neg",      4'd2,  4'd5, 1'b0);
        run_op("ignore",   4'd6,  4'd11, 1'b1);

        // Abort in the second SHIFT cycle after a nonzero result exists.
        run_op("pre_rst", 4'd12, 4'd5, 1'b0);
        @(negedge clk);
        a     = 4'd3;
        b     = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.diff",   32'(diff),   32'(0));
        check("abort.borrow", 32'(borrow), 32'(0));
        check("abort.ovf",    32'(ovf),    32'(0));
        check("abort.busy",   32'(busy),   32'(0));
        check("abort.done",   32'(done),   32'(0));
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("abort.no_done", 32'(nd), 32'(0));
        run_op("post_rst", 4'd3, 4'd9, 1'b0);

        // Reset released while start is held: accepted on first edge.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd5;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("rel.busy", 32'(busy), 32'(1));
        nb = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            nb++;
            @(negedge clk);
        end
        check("rel.done", 32'(done), 32'(1));
        check("rel.cyc",  32'(nb),   32'(W));
        check_result("rel", 4'd2, 4'd5);
        @(negedge clk);

        // Randomized single operations.
        for (int k = 0; k < 24; k++) begin
            run_op($sformatf("rnd%0d", k), W'($urandom), W'($urandom),
                   1'($urandom_range(0, 3) == 0));
        end

        // Continuous start: one operation every W+2 clocks.
        ca = W'($urandom);
        cb = W'($urandom);
        @(negedge clk);
        a      = ca;
        b      = cb;
        start  = 1'b1;
        prev   = -1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && done) check("cont.overlap", 32'(1), 32'(0));
            if (done) begin
                pulses++;
                if (prev >= 0) check("cont.period", 32'(i - prev), 32'(W + 2));
                check_result("cont", ca, cb);
                prev = i;
            end
        end
        start = 1'b0;
        check("cont.pulses", 32'(pulses >= 6), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
